acc_readout: RTL
================

ACC_READOUT -- requirements
Module: acc_readout

Interface
REQ-001 The block SHALL have parameter SHIFT, default 8, meaning the right-shift (scale) applied to the captured sum; legal values are 0..16.
REQ-002 clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  request to read out and clear the accumulator; sampled only in IDLE.
REQ-005 sum_i  input  28  signed two's-complement running sum from the accumulator.
REQ-006 acc_clr  output  1  one-cycle pulse, wired to the accumulator reset, clears its running sum.
REQ-007 busy  output  1  high whenever the state is not IDLE.
REQ-008 y_o  output  12  signed scaled and saturated result.
REQ-009 valid_o  output  1  y_o is valid.
REQ-010 ready_i  input  1  downstream accepts y_o.

Function
REQ-011 The block SHALL implement four states: IDLE, SHIFT, SAT and HOLD.
REQ-012 In IDLE with start=1, the block SHALL capture sum_i into a 28-bit work register, load a counter with SHIFT, go to SHIFT (or directly to SAT if SHIFT=0), and drive acc_clr=1 for exactly the next cycle.
REQ-013 In SHIFT, each cycle SHALL perform one arithmetic right shift by 1 (sign preserved), store the shifted-out bit as the round bit, and decrement the counter; after SHIFT such cycles the block SHALL enter SAT.
REQ-014 The round bit SHALL be 0 when SHIFT=0.
REQ-015 In SAT, the block SHALL form a 29-bit value (work register plus optional round bit, see REQ-023/024), clamp it to [-2048, +2047], load y_o, set valid_o=1 and enter HOLD.
REQ-016 Latency SHALL be fixed: valid_o rises SHIFT+1 clock edges after the edge that samples start.
REQ-017 In HOLD, valid_o and y_o SHALL stay stable until valid_o and ready_i are both high at a rising edge; on that edge the block SHALL clear valid_o and return to IDLE.
REQ-018 y_o SHALL retain its last value after the handshake until the next SAT.
REQ-019 start SHALL be ignored in SHIFT, SAT and HOLD, including the handshake cycle; a new request needs start high while in IDLE.
REQ-020 sum_i SHALL be sampled only on the start edge; later changes SHALL NOT affect the result.

Reset
REQ-021 rst=1 at a rising edge SHALL force IDLE and set y_o=0, valid_o=0, acc_clr=0, busy=0 and the counter to 0, from any state, mid-operation included.
REQ-022 rst SHALL take priority over start and ready_i in the same cycle.

Configuration
REQ-023 With macro ACC_READOUT_ROUND_EN defined, SAT SHALL add the round bit (round half up) before saturation.
REQ-024 Without ACC_READOUT_ROUND_EN, the round bit SHALL be ignored (truncation toward minus infinity); all other behaviour and latency are identical.

Verification (SHIFT=8)
REQ-025 Rounding: sum_i=0x0001280, start -> y_o=0x013 (ROUND_EN) / 0x012 (truncation); valid_o rises on the 9th edge after start; acc_clr high for exactly 1 cycle after start.
REQ-026 Saturation: sum_i=0x0100000 -> y_o=0x7FF; sum_i=0xF000000 -> y_o=0x800; sum_i=0xFFFFF00 -> y_o=0xFFF.
REQ-027 Round overflow: sum_i=0x007FF80 -> y_o=0x7FF in both builds (ROUND_EN gives 2048, which clamps to 2047).
REQ-028 Backpressure: ready_i low for 5 cycles in HOLD, with start pulsed during that time -> y_o and valid_o stable, no second acc_clr; ready_i=1 -> valid_o low next cycle, busy low.
REQ-029 Reset mid-operation: rst in the 3rd SHIFT cycle -> next edge y_o=0, valid_o=0, busy=0, acc_clr=0; no valid_o follows; a subsequent start works normally.
REQ-030 SHIFT=0 build: sum_i=0x0000123 -> y_o=0x123 with valid_o 1 edge after start; sum_i=0x0000800 -> y_o=0x7FF.

Source files
------------

// File: rtl/acc_readout.sv
// acc_readout: reads out and clears an accumulator, then shifts, saturates and hands off the result.
// Define ACC_READOUT_ROUND_EN for round-half-up; the default build truncates.
module acc_readout #(
    parameter int SHIFT = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [27:0] sum_i,
    output logic        acc_clr,
    output logic        busy,
    output logic [11:0] y_o,
    output logic        valid_o,
    input  logic        ready_i
);
`ifdef ACC_READOUT_ROUND_EN
    localparam logic RND = 1'b1;
`else
    localparam logic RND = 1'b0;
`endif
    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_SAT, S_HOLD} state_t;
    state_t state, state_n;
    logic [27:0] work;
    logic        rnd;
    logic [4:0]  cnt;
    logic [28:0] v;
    logic [11:0] sat;
    logic        go;
    assign go   = state == S_IDLE && start;
    assign busy = state != S_IDLE;
    always_comb begin
        state_n = state;
        if (go) state_n = (SHIFT == 0) ? S_SAT : S_SHIFT;
        if (state == S_SHIFT && cnt == 5'd1) state_n = S_SAT;
        if (state == S_SAT) state_n = S_HOLD;
        if (state == S_HOLD && valid_o && ready_i) state_n = S_IDLE;
    end
    // 29 bits so the rounding increment can never wrap before the clamp
    always_comb begin
        v   = {work[27], work} + {28'd0, rnd & RND};
        sat = ($signed(v) > 29'sd2047) ? 12'h7ff : ($signed(v) < -29'sd2048) ? 12'h800 : v[11:0];
    end
    always_ff @(posedge clk) state <= rst ? S_IDLE : state_n;
    always_ff @(posedge clk) begin
        if (rst) begin
            work    <= '0;
            rnd     <= 1'b0;
            cnt     <= '0;
            y_o     <= '0;
            valid_o <= 1'b0;
            acc_clr <= 1'b0;
        end else begin
            acc_clr <= go;
            if (go) begin
                work <= sum_i;
                rnd  <= 1'b0;
                cnt  <= 5'(SHIFT);
            end
            if (state == S_SHIFT) begin
                work <= {work[27], work[27:1]};
                rnd  <= work[0];
                cnt  <= cnt - 5'd1;
            end
            if (state == S_SAT) begin
                y_o     <= sat;
                valid_o <= 1'b1;
            end
            if (state == S_HOLD && ready_i) valid_o <= 1'b0;
        end
    end
endmodule
